cpu_axi_master: RTL and testbench
=================================

CPU_AXI_MASTER -- requirements
Module: cpu_axi_master

Interface
REQ-001 SHALL have parameter MASTER_ID, default 4'd0, meaning the value driven on ARID and AWID.
REQ-002 SHALL have ports clk (input, 1, clock) and rst (input, 1, reset, asynchronous, active-high).
REQ-003 SHALL have core-side inputs: req (1, access request), we (1, write when 1), addr (32, byte address), wdata (32, write data), wstrb (4, byte enables, active-high).
REQ-004 SHALL have core-side outputs: stall (1, access not yet complete), done (1, one-cycle completion pulse), rdata (32, read data).
REQ-005 SHALL have read-address outputs ARID (4), ARADDR (32), ARLEN (4), ARSIZE (3), ARBURST (2) and ARVALID (1), plus input ARREADY (1).
REQ-006 SHALL have read-data inputs RID (4), RDATA (32), RRESP (2), RLAST (1) and RVALID (1), plus output RREADY (1).
REQ-007 SHALL have write-address outputs AWID, AWADDR, AWLEN, AWSIZE, AWBURST and AWVALID (widths as AR), plus input AWREADY.
REQ-008 SHALL have write-data outputs WDATA (32), WSTRB (4), WLAST (1) and WVALID (1), plus input WREADY (1).
REQ-009 SHALL have write-response inputs BID (4), BRESP (2) and BVALID (1), plus output BREADY (1).

Function
REQ-010 SHALL implement states IDLE, RADDR, RDATA, WADDR, WDATA and WRESP.
REQ-011 In IDLE with req=1, SHALL latch addr, wdata and wstrb, and go to WADDR if we=1, otherwise to RADDR.
REQ-012 In IDLE with req=0, SHALL remain in IDLE.
REQ-013 SHALL drive constant fields: LEN 4'd0, SIZE 3'b010 and BURST 2'b01 (INCR).
REQ-014 SHALL drive ARADDR and AWADDR from the latched address, with bits [1:0] forced to 0.
REQ-015 In RADDR, SHALL assert ARVALID and hold it and all AR fields stable until ARREADY=1 is sampled, then go to RDATA.
REQ-016 In RDATA, SHALL assert RREADY.
REQ-017 On a sampled RVALID&RLAST, SHALL register RDATA into rdata, pulse done for one cycle and return to IDLE.
REQ-018 Beats with RLAST=0 SHALL be accepted and discarded.
REQ-019 In WADDR, SHALL assert AWVALID until AWREADY=1 is sampled, then go to WDATA.
REQ-020 WVALID SHALL NOT be asserted before the AW handshake completes.
REQ-021 In WDATA, SHALL assert WVALID and WLAST=1 with the latched WDATA and WSTRB until WREADY=1 is sampled, then go to WRESP.
REQ-022 In WRESP, SHALL assert BREADY; on BVALID=1, SHALL pulse done and return to IDLE.
REQ-023 stall SHALL equal (state!=IDLE) | req, and SHALL be 0 in the cycle done=1.
REQ-024 A new req in the cycle after done SHALL be accepted.
REQ-025 Changes on req, addr, we, wdata or wstrb while the state is not IDLE SHALL be ignored.
REQ-026 RID, BID, RRESP and BRESP SHALL be ignored except as given in REQ-032.
REQ-027 rdata SHALL hold its value until the next completed read.
REQ-028 Latency with zero-wait slaves SHALL be: req sampled at cycle 0, ARVALID at cycle 1, RREADY at cycle 2, done at cycle 3 when RVALID arrives at cycle 2.
REQ-029 Write latency with zero-wait slaves SHALL be: AWVALID at cycle 1, WVALID at cycle 2, BREADY at cycle 3, done at cycle 4 when BVALID arrives at cycle 3.

Reset
REQ-030 rst SHALL force state to IDLE and drive ARVALID, AWVALID, WVALID, RREADY, BREADY, done and WLAST to 0, and rdata to 0, asynchronously.
REQ-031 A reset asserted mid-transaction SHALL abandon the transaction with no done pulse.

Configuration
REQ-032 With macro CPU_AXI_RESP_ERR_EN defined, SHALL add output err (1), set sticky on a completing R or B beat whose RRESP or BRESP is not 2'b00, and clear it only on rst; done SHALL still pulse.
REQ-033 Without CPU_AXI_RESP_ERR_EN, the err port SHALL be absent and RRESP and BRESP SHALL be ignored.

Verification
REQ-034 Read addr=0x0000_0104 with zero-wait slave and RDATA=0xDEADBEEF at cycle 2 -> ARADDR=0x104, ARLEN=0, done at cycle 3, rdata=0xDEADBEEF.
REQ-035 Write addr=0x10, wdata=0x12345678, wstrb=4'b0011, with AWREADY delayed 3 cycles -> AWVALID held 4 cycles, then WVALID/WLAST with WSTRB=0011, done one cycle after BVALID.
REQ-036 Read addr=0x0000_0003 -> ARADDR=0x0000_0000.
REQ-037 Read with RVALID pulses of RLAST=0 (0x1111), then RLAST=1 (0x2222) -> rdata=0x2222, single done.
REQ-038 rst asserted while in WDATA -> WVALID=0 immediately and no done pulse; the next req is accepted normally.
REQ-039 With CPU_AXI_RESP_ERR_EN defined, BRESP=2'b10 -> err=1 and stays 1 across subsequent OKAY reads until rst.

Source files
------------

// File: rtl/cpu_axi_master.sv
// cpu_axi_master: bridges a simple single-access core port (req/we/addr/
// wdata/wstrb -> stall/done/rdata) onto an AXI master with single-beat,
// 32-bit, INCR transactions. One access is in flight at a time.
//
// Optional build macro CPU_AXI_RESP_ERR_EN adds a sticky 'err' output that
// records any non-OKAY RRESP/BRESP on a completing beat.
//
// Handshake rule on every AXI channel: a transfer happens on a rising clk edge
// where VALID and READY are both 1. Once this master raises a VALID it keeps it
// high, with the payload stable, until that edge; it never waits for READY
// before raising VALID. The READY outputs (RREADY, BREADY) are raised only in
// the state that expects the matching response.
module cpu_axi_master #(
   parameter logic [3:0] MASTER_ID = 4'd0
) (
   input  logic        clk,
   input  logic        rst,
   // core side
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic [2:0]  dbg_state,
   // read address channel
   output logic [3:0]  ARID,
   output logic [31:0] ARADDR,
   output logic [3:0]  ARLEN,
   output logic [2:0]  ARSIZE,
   output logic [1:0]  ARBURST,
   output logic        ARVALID,
   input  logic        ARREADY,
   // read data channel
   input  logic [3:0]  RID,
   input  logic [31:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RLAST,
   input  logic        RVALID,
   output logic        RREADY,
   // write address channel
   output logic [3:0]  AWID,
   output logic [31:0] AWADDR,
   output logic [3:0]  AWLEN,
   output logic [2:0]  AWSIZE,
   output logic [1:0]  AWBURST,
   output logic        AWVALID,
   input  logic        AWREADY,
   // write data channel
   output logic [31:0] WDATA,
   output logic [3:0]  WSTRB,
   output logic        WLAST,
   output logic        WVALID,
   input  logic        WREADY,
   // write response channel
   input  logic [3:0]  BID,
   input  logic [1:0]  BRESP,
   input  logic        BVALID,
   output logic        BREADY
`ifdef CPU_AXI_RESP_ERR_EN
   ,
   output logic        err
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RADDR = 3'd1,
      ST_RDATA = 3'd2,
      ST_WADDR = 3'd3,
      ST_WDATA = 3'd4,
      ST_WRESP = 3'd5
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [31:2] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        accept;
   logic        complete;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and channel-control decode. A req seen during the done cycle
   // is the request that just finished, so IDLE accepts only once done is low.
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      complete = 1'b0;
      ARVALID  = 1'b0;
      RREADY   = 1'b0;
      AWVALID  = 1'b0;
      WVALID   = 1'b0;
      WLAST    = 1'b0;
      BREADY   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req && !done) begin
               accept  = 1'b1;
               state_d = we ? ST_WADDR : ST_RADDR;
            end
         end
         ST_RADDR: begin
            ARVALID = 1'b1;
            if (ARREADY) state_d = ST_RDATA;
         end
         ST_RDATA: begin
            RREADY = 1'b1;
            // beats without RLAST are taken and dropped
            if (RVALID && RLAST) begin
               complete = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_WADDR: begin
            AWVALID = 1'b1;
            if (AWREADY) state_d = ST_WDATA;
         end
         ST_WDATA: begin
            WVALID = 1'b1;
            WLAST  = 1'b1;
            if (WREADY) state_d = ST_WRESP;
         end
         ST_WRESP: begin
            BREADY = 1'b1;
            if (BVALID) begin
               complete = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture the core request when it is accepted; later core changes are ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else if (accept) begin
         addr_q  <= addr[31:2];
         wdata_q <= wdata;
         wstrb_q <= wstrb;
      end
   end

   // Completion pulse and read-data register (rdata holds until the next read completes)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done  <= 1'b0;
         rdata <= '0;
      end else begin
         done <= complete;
         if (complete && (state_q == ST_RDATA)) rdata <= RDATA;
      end
   end

`ifdef CPU_AXI_RESP_ERR_EN
   // Sticky error flag: any non-OKAY response on a completing beat, cleared only by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (complete) begin
         if ((state_q == ST_RDATA && RRESP != 2'b00) ||
             (state_q == ST_WRESP && BRESP != 2'b00))
            err <= 1'b1;
      end
   end

   logic unused_ids;
   assign unused_ids = ^{RID, BID};
`else
   logic unused_ids;
   assign unused_ids = ^{RID, BID, RRESP, BRESP};
`endif

   // Core sees stall while busy or requesting, but never during the done cycle
   assign stall     = ((state_q != ST_IDLE) | req) & ~done;
   assign dbg_state = state_q;

   // Fixed single-beat word transfers, word-aligned address
   assign ARID    = MASTER_ID;
   assign ARADDR  = {addr_q, 2'b00};
   assign ARLEN   = 4'd0;
   assign ARSIZE  = 3'b010;
   assign ARBURST = 2'b01;

   assign AWID    = MASTER_ID;
   assign AWADDR  = {addr_q, 2'b00};
   assign AWLEN   = 4'd0;
   assign AWSIZE  = 3'b010;
   assign AWBURST = 2'b01;

   assign WDATA   = wdata_q;
   assign WSTRB   = wstrb_q;

endmodule

// File: tb/tb_cpu_axi_master.sv
// Testbench for cpu_axi_master. The bench plays both the core and the AXI
// slave. Directed scenarios cover latency, address alignment, multi-beat
// reads, delayed handshakes and mid-transaction reset; a random phase runs
// mixed reads/writes against a word-level memory model.
// Define CPU_AXI_RESP_ERR_EN to build and check the err output.
`timescale 1ns/1ps
module tb_cpu_axi_master;

   localparam logic [3:0] ID = 4'hA;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  wstrb;
   logic        stall, done;
   logic [31:0] rdata;
   logic [2:0]  dbg_state;
   logic [3:0]  ARID, ARLEN, AWID, AWLEN;
   logic [31:0] ARADDR, AWADDR;
   logic [2:0]  ARSIZE, AWSIZE;
   logic [1:0]  ARBURST, AWBURST;
   logic        ARVALID, ARREADY, AWVALID, AWREADY;
   logic [3:0]  RID, BID;
   logic [31:0] RDATA, WDATA;
   logic [1:0]  RRESP, BRESP;
   logic        RLAST, RVALID, RREADY;
   logic [3:0]  WSTRB;
   logic        WLAST, WVALID, WREADY;
   logic        BVALID, BREADY;
`ifdef CPU_AXI_RESP_ERR_EN
   logic        err;
`endif

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   // slave memory (filled from what the DUT puts on W) and core-side model
   logic [31:0] slave_mem [int];
   logic [31:0] model_mem [int];

   typedef struct packed {
      logic [31:0] araddr;
      logic [3:0]  arid;
      logic [3:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic        ar_first;
      logic        stall_busy;
      logic        hold_ok;
      int          rready_cyc;
      logic [31:0] rdata_mid;
      int          done_cyc;
      logic        stall_at_done;
      logic [31:0] rdata;
      logic        done_after;
      int          pulses;
   } rd_obs_t;

   typedef struct packed {
      logic [31:0] awaddr;
      logic [3:0]  awid;
      logic [3:0]  awlen;
      logic [2:0]  awsize;
      logic [1:0]  awburst;
      logic        aw_first;
      logic        stall_busy;
      logic        hold_ok;
      int          aw_cycles;
      int          wvalid_cyc;
      logic        awvalid_after;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        wlast;
      int          bready_cyc;
      logic        wvalid_after;
      int          done_cyc;
      logic        stall_at_done;
      logic        done_after;
      int          pulses;
   } wr_obs_t;

   cpu_axi_master #(.MASTER_ID(ID)) dut (
      .clk(clk), .rst(rst),
      .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .stall(stall), .done(done), .rdata(rdata), .dbg_state(dbg_state),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
      .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
      .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
`ifdef CPU_AXI_RESP_ERR_EN
      , .err(err)
`endif
   );

   // clock and done-pulse counter
   always #5 clk = ~clk;
   always @(negedge clk) if (done === 1'b1) done_seen++;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks (observe only, no judgement) ----------------
   task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input int ar_wait,
                           input int n_junk, input logic [1:0] resp, input bit use_mem,
                           output rd_obs_t o);
      int cyc;
      int d0;
      int k;
      logic [31:0] dv;
      o = '0;
      d0 = done_seen;
      req = 1'b1; we = 1'b0; addr = a; wdata = $urandom; wstrb = 4'($urandom);
      tick(); cyc = 1; req = 1'b0;
      o.araddr = ARADDR; o.arid = ARID; o.arlen = ARLEN; o.arsize = ARSIZE; o.arburst = ARBURST;
      o.ar_first = ARVALID; o.stall_busy = stall; o.hold_ok = 1'b1;
      for (int i = 0; i < ar_wait; i++) begin
         req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1)); addr = $urandom;
         tick(); cyc++;
         if (!(ARVALID === 1'b1 && ARADDR === o.araddr && RREADY === 1'b0)) o.hold_ok = 1'b0;
      end
      req = 1'b0;
      ARREADY = 1'b1; tick(); cyc++; ARREADY = 1'b0;
      o.rready_cyc = (RREADY === 1'b1) ? cyc : -1;
      for (int j = 0; j < n_junk; j++) begin
         RVALID = 1'b1; RLAST = 1'b0; RDATA = 32'h0000_1111; RRESP = resp; RID = 4'($urandom);
         tick(); cyc++;
         RVALID = 1'b0;
      end
      o.rdata_mid = rdata;
      dv = d;
      if (use_mem) begin
         k = int'(o.araddr >> 2);
         dv = slave_mem.exists(k) ? slave_mem[k] : 32'h0;
      end
      RVALID = 1'b1; RLAST = 1'b1; RDATA = dv; RRESP = resp; RID = 4'($urandom);
      tick(); cyc++;
      RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
      o.done_cyc = -1;
      for (int p = 0; p < 6; p++) begin
         if (done === 1'b1) begin
            o.done_cyc = cyc; o.stall_at_done = stall; o.rdata = rdata;
            break;
         end
         tick(); cyc++;
      end
      tick();
      o.done_after = done;
      o.pulses = done_seen - d0;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_wait, input int w_wait, input int b_wait,
                            input logic [1:0] resp, output wr_obs_t o);
      int cyc;
      int d0;
      int k;
      logic [31:0] w;
      o = '0;
      d0 = done_seen;
      req = 1'b1; we = 1'b1; addr = a; wdata = d; wstrb = s;
      tick(); cyc = 1; req = 1'b0;
      o.awaddr = AWADDR; o.awid = AWID; o.awlen = AWLEN; o.awsize = AWSIZE; o.awburst = AWBURST;
      o.aw_first = AWVALID; o.stall_busy = stall; o.hold_ok = 1'b1;
      for (int i = 0; i < aw_wait; i++) begin
         if (AWVALID === 1'b1) o.aw_cycles++;
         if (WVALID !== 1'b0 || AWADDR !== o.awaddr) o.hold_ok = 1'b0;
         req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
         addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
         tick(); cyc++;
      end
      req = 1'b0;
      if (AWVALID === 1'b1) o.aw_cycles++;
      if (WVALID !== 1'b0) o.hold_ok = 1'b0;
      AWREADY = 1'b1; tick(); cyc++; AWREADY = 1'b0;
      o.wvalid_cyc = (WVALID === 1'b1) ? cyc : -1;
      o.awvalid_after = AWVALID; o.wdata = WDATA; o.wstrb = WSTRB; o.wlast = WLAST;
      for (int i = 0; i < w_wait; i++) begin
         req = 1'($urandom_range(0, 1)); wdata = $urandom; wstrb = 4'($urandom);
         tick(); cyc++;
         if (!(WVALID === 1'b1 && WLAST === 1'b1 && WDATA === o.wdata && WSTRB === o.wstrb))
            o.hold_ok = 1'b0;
      end
      req = 1'b0;
      WREADY = 1'b1; tick(); cyc++; WREADY = 1'b0;
      o.bready_cyc = (BREADY === 1'b1) ? cyc : -1;
      o.wvalid_after = WVALID;
      k = int'(o.awaddr >> 2);
      w = slave_mem.exists(k) ? slave_mem[k] : 32'h0;
      for (int b = 0; b < 4; b++) if (o.wstrb[b]) w[b*8 +: 8] = o.wdata[b*8 +: 8];
      slave_mem[k] = w;
      for (int i = 0; i < b_wait; i++) begin
         tick(); cyc++;
      end
      BVALID = 1'b1; BRESP = resp; BID = 4'($urandom);
      tick(); cyc++;
      BVALID = 1'b0; BRESP = 2'b00;
      o.done_cyc = -1;
      for (int p = 0; p < 6; p++) begin
         if (done === 1'b1) begin
            o.done_cyc = cyc; o.stall_at_done = stall;
            break;
         end
         tick(); cyc++;
      end
      tick();
      o.done_after = done;
      o.pulses = done_seen - d0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++; if ({ARVALID, AWVALID, WVALID, RREADY, BREADY, WLAST, done} !== 7'b0)
         begin errors++; $display("FAIL reset_ctrl: got %b want 0000000", {ARVALID, AWVALID, WVALID, RREADY, BREADY, WLAST, done}); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
      req = 1'b1; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_follows_req: got %b want 1", stall); end
      req = 1'b0;
      @(negedge clk); rst = 1'b0;
      tick(); tick();
      checks++; if ({ARVALID, AWVALID, WVALID, RREADY, BREADY, done} !== 6'b0)
         begin errors++; $display("FAIL idle_after_reset: got %b want 000000", {ARVALID, AWVALID, WVALID, RREADY, BREADY, done}); end
   endtask

   task automatic test_read_basic();
      rd_obs_t o;
      axi_read(32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 2'b00, 1'b0, o);
      checks++; if (o.araddr !== 32'h104) begin errors++; $display("FAIL rd_araddr: got %h want 104", o.araddr); end
      checks++; if ({o.arid, o.arlen, o.arsize, o.arburst} !== {ID, 4'd0, 3'b010, 2'b01})
         begin errors++; $display("FAIL rd_fields: got %h want %h", {o.arid, o.arlen, o.arsize, o.arburst}, {ID, 4'd0, 3'b010, 2'b01}); end
      checks++; if (o.ar_first !== 1'b1 || o.stall_busy !== 1'b1)
         begin errors++; $display("FAIL rd_cycle1: arvalid %b stall %b want 1 1", o.ar_first, o.stall_busy); end
      checks++; if (o.rready_cyc !== 2) begin errors++; $display("FAIL rd_rready_cyc: got %0d want 2", o.rready_cyc); end
      checks++; if (o.done_cyc !== 3) begin errors++; $display("FAIL rd_done_cyc: got %0d want 3", o.done_cyc); end
      checks++; if (o.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", o.rdata); end
      checks++; if (o.stall_at_done !== 1'b0) begin errors++; $display("FAIL rd_stall_done: got %b want 0", o.stall_at_done); end
      checks++; if (o.pulses !== 1 || o.done_after !== 1'b0)
         begin errors++; $display("FAIL rd_single_done: pulses %0d after %b want 1 0", o.pulses, o.done_after); end
   endtask

   task automatic test_read_unaligned();
      rd_obs_t o;
      axi_read(32'h0000_0003, 32'h0BAD_F00D, 2, 0, 2'b00, 1'b0, o);
      checks++; if (o.araddr !== 32'h0) begin errors++; $display("FAIL unaligned_araddr: got %h want 0", o.araddr); end
      checks++; if (o.hold_ok !== 1'b1) begin errors++; $display("FAIL ar_hold: got %b want 1", o.hold_ok); end
      checks++; if (o.done_cyc !== 5) begin errors++; $display("FAIL unaligned_done_cyc: got %0d want 5", o.done_cyc); end
      checks++; if (rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL rdata_hold: got %h want 0badf00d", rdata); end
   endtask

   task automatic test_read_multibeat();
      rd_obs_t o;
      axi_read(32'h0000_0080, 32'h55AA_55AA, 0, 0, 2'b00, 1'b0, o);
      axi_read(32'h0000_0084, 32'h0000_2222, 0, 2, 2'b00, 1'b0, o);
      checks++; if (o.rdata_mid !== 32'h55AA_55AA) begin errors++; $display("FAIL junk_beat_rdata: got %h want 55aa55aa", o.rdata_mid); end
      checks++; if (o.rdata !== 32'h0000_2222) begin errors++; $display("FAIL multibeat_rdata: got %h want 2222", o.rdata); end
      checks++; if (o.pulses !== 1) begin errors++; $display("FAIL multibeat_pulses: got %0d want 1", o.pulses); end
      checks++; if (o.done_cyc !== 5) begin errors++; $display("FAIL multibeat_done_cyc: got %0d want 5", o.done_cyc); end
   endtask

   task automatic test_write_delayed();
      wr_obs_t o;
      axi_write(32'h0000_0010, 32'h1234_5678, 4'b0011, 3, 0, 0, 2'b00, o);
      checks++; if (o.awaddr !== 32'h10) begin errors++; $display("FAIL wr_awaddr: got %h want 10", o.awaddr); end
      checks++; if ({o.awid, o.awlen, o.awsize, o.awburst} !== {ID, 4'd0, 3'b010, 2'b01})
         begin errors++; $display("FAIL wr_fields: got %h want %h", {o.awid, o.awlen, o.awsize, o.awburst}, {ID, 4'd0, 3'b010, 2'b01}); end
      checks++; if (o.aw_cycles !== 4) begin errors++; $display("FAIL awvalid_cycles: got %0d want 4", o.aw_cycles); end
      checks++; if (o.hold_ok !== 1'b1) begin errors++; $display("FAIL wr_hold: got %b want 1", o.hold_ok); end
      checks++; if (o.wvalid_cyc !== 5 || o.awvalid_after !== 1'b0)
         begin errors++; $display("FAIL wvalid_cyc: got %0d awvalid %b want 5 0", o.wvalid_cyc, o.awvalid_after); end
      checks++; if ({o.wdata, o.wstrb, o.wlast} !== {32'h1234_5678, 4'b0011, 1'b1})
         begin errors++; $display("FAIL wr_payload: got %h %b %b want 12345678 0011 1", o.wdata, o.wstrb, o.wlast); end
      checks++; if (o.bready_cyc !== 6 || o.wvalid_after !== 1'b0)
         begin errors++; $display("FAIL bready_cyc: got %0d wvalid %b want 6 0", o.bready_cyc, o.wvalid_after); end
      checks++; if (o.done_cyc !== 7 || o.pulses !== 1)
         begin errors++; $display("FAIL wr_done: cyc %0d pulses %0d want 7 1", o.done_cyc, o.pulses); end
   endtask

   task automatic test_back_to_back();
      wr_obs_t wo;
      rd_obs_t ro;
      axi_write(32'h0000_0020, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b00, wo);
      checks++; if (wo.aw_first !== 1'b1 || wo.wvalid_cyc !== 2 || wo.bready_cyc !== 3 || wo.done_cyc !== 4)
         begin errors++; $display("FAIL wr_latency: aw %b w %0d b %0d done %0d want 1 2 3 4", wo.aw_first, wo.wvalid_cyc, wo.bready_cyc, wo.done_cyc); end
      checks++; if (wo.stall_at_done !== 1'b0) begin errors++; $display("FAIL wr_stall_done: got %b want 0", wo.stall_at_done); end
      axi_read(32'h0000_0022, 32'h0, 0, 0, 2'b00, 1'b1, ro);
      checks++; if (ro.ar_first !== 1'b1 || ro.done_cyc !== 3)
         begin errors++; $display("FAIL b2b_read: arvalid %b done %0d want 1 3", ro.ar_first, ro.done_cyc); end
      checks++; if (ro.rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_rdata: got %h want cafef00d", ro.rdata); end
   endtask

   task automatic test_reset_mid_write();
      rd_obs_t ro;
      int d0;
      axi_read(32'h0000_0200, 32'hA5A5_0001, 0, 0, 2'b00, 1'b0, ro);
      d0 = done_seen;
      req = 1'b1; we = 1'b1; addr = 32'h300; wdata = 32'hFEED_BEEF; wstrb = 4'hF;
      tick(); req = 1'b0;
      AWREADY = 1'b1; tick(); AWREADY = 1'b0;
      checks++; if (WVALID !== 1'b1) begin errors++; $display("FAIL pre_reset_wvalid: got %b want 1", WVALID); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({WVALID, WLAST, BREADY, done} !== 4'b0)
         begin errors++; $display("FAIL async_reset_ctrl: got %b want 0000", {WVALID, WLAST, BREADY, done}); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL async_reset_rdata: got %h want 0", rdata); end
      @(negedge clk); rst = 1'b0;
      WREADY = 1'b1; BVALID = 1'b1;
      tick(); tick(); tick();
      WREADY = 1'b0; BVALID = 1'b0;
      tick();
      checks++; if (done_seen !== d0) begin errors++; $display("FAIL abandon_no_done: got %0d want %0d", done_seen, d0); end
      checks++; if ({WVALID, BREADY, stall} !== 3'b0)
         begin errors++; $display("FAIL abandon_idle: got %b want 000", {WVALID, BREADY, stall}); end
      axi_read(32'h0000_0304, 32'h0BAD_CAFE, 1, 0, 2'b00, 1'b0, ro);
      checks++; if (ro.done_cyc !== 4 || ro.rdata !== 32'h0BAD_CAFE || ro.pulses !== 1)
         begin errors++; $display("FAIL post_reset_read: cyc %0d rdata %h pulses %0d want 4 0badcafe 1", ro.done_cyc, ro.rdata, ro.pulses); end
   endtask

`ifdef CPU_AXI_RESP_ERR_EN
   task automatic test_err();
      wr_obs_t wo;
      rd_obs_t ro;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_initial: got %b want 0", err); end
      axi_write(32'h0000_0040, 32'h1, 4'hF, 0, 0, 0, 2'b10, wo);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err); end
      checks++; if (wo.pulses !== 1) begin errors++; $display("FAIL err_done: got %0d want 1", wo.pulses); end
      axi_read(32'h0000_0044, 32'h77, 0, 0, 2'b00, 1'b0, ro);
      axi_read(32'h0000_0048, 32'h78, 1, 0, 2'b00, 1'b0, ro);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
      #2 rst = 1'b1;
      #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
      @(negedge clk); rst = 1'b0;
      tick();
   endtask
`endif

   task automatic test_random();
      rd_obs_t ro;
      wr_obs_t wo;
      logic [31:0] a, d, w, exp;
      logic [3:0]  s;
      logic [1:0]  resp;
      int k, aw, ww, bw, nj;
      for (int n = 0; n < 30; n++) begin
         a = ($urandom_range(0, 1) == 1 ? 32'h8000_1000 : 32'h0000_1000) | 32'($urandom_range(0, 31));
         k = int'(a >> 2);
         resp = 2'($urandom_range(0, 3));
         aw = $urandom_range(0, 3); ww = $urandom_range(0, 3); bw = $urandom_range(0, 3);
         nj = $urandom_range(0, 2);
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom; s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, aw, ww, bw, resp, wo);
            w = model_mem.exists(k) ? model_mem[k] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
            model_mem[k] = w;
            checks++; if (wo.awaddr !== (a & ~32'h3)) begin errors++; $display("FAIL rnd_awaddr: got %h want %h", wo.awaddr, a & ~32'h3); end
            checks++; if ({wo.wdata, wo.wstrb, wo.wlast} !== {d, s, 1'b1})
               begin errors++; $display("FAIL rnd_wpayload: got %h %b want %h %b", wo.wdata, wo.wstrb, d, s); end
            checks++; if (wo.hold_ok !== 1'b1 || wo.aw_cycles !== aw + 1)
               begin errors++; $display("FAIL rnd_whold: ok %b awcyc %0d want 1 %0d", wo.hold_ok, wo.aw_cycles, aw + 1); end
            checks++; if (wo.done_cyc !== aw + ww + bw + 4 || wo.pulses !== 1)
               begin errors++; $display("FAIL rnd_wdone: cyc %0d pulses %0d want %0d 1", wo.done_cyc, wo.pulses, aw + ww + bw + 4); end
         end else begin
            axi_read(a, 32'h0, aw, nj, resp, 1'b1, ro);
            exp = model_mem.exists(k) ? model_mem[k] : 32'h0;
            checks++; if (ro.araddr !== (a & ~32'h3)) begin errors++; $display("FAIL rnd_araddr: got %h want %h", ro.araddr, a & ~32'h3); end
            checks++; if (ro.rdata !== exp) begin errors++; $display("FAIL rnd_rdata: got %h want %h", ro.rdata, exp); end
            checks++; if (ro.hold_ok !== 1'b1 || ro.rready_cyc !== aw + 2)
               begin errors++; $display("FAIL rnd_rhold: ok %b rready %0d want 1 %0d", ro.hold_ok, ro.rready_cyc, aw + 2); end
            checks++; if (ro.done_cyc !== aw + nj + 3 || ro.pulses !== 1)
               begin errors++; $display("FAIL rnd_rdone: cyc %0d pulses %0d want %0d 1", ro.done_cyc, ro.pulses, aw + nj + 3); end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
      ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
      RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
      BID = '0; BRESP = '0; BVALID = 1'b0;
      test_reset();
`ifdef CPU_AXI_RESP_ERR_EN
      test_err();
`endif
      test_read_basic();
      test_read_unaligned();
      test_read_multibeat();
      test_write_delayed();
      test_back_to_back();
      test_reset_mid_write();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
